// File: rtl/abc_ram_dp_param.sv
// Simple-dual-port RAM with a shared clock, an optional zero-fill sequencer after reset, and a selectable same-address collision policy.
// Read data arrives RDLAT (1 or 2) cycles after REN; there is no backpressure, and a read is accepted on any RUN edge with REN high.
module abc_ram_dp_param #(
  parameter int DWIDTH         = 8,
  parameter int AWIDTH         = 8,
  parameter int RDLAT          = 1,
  parameter int COLLISION_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              RWCLK,
  input  logic              RESETN,
  input  logic              WEN,
  input  logic              REN,
  input  logic [AWIDTH-1:0] WADDR,
  input  logic [AWIDTH-1:0] RADDR,
  input  logic [DWIDTH-1:0] WD,
  output logic [DWIDTH-1:0] RD,
  output logic              RVALID,
  output logic              INIT_BUSY
);

  localparam int DEPTH      = 1 << AWIDTH;
  localparam bit WR_THROUGH = (COLLISION_MODE == 1);
  localparam bit DO_CLEAR   = (CLEAR_ON_RESET != 0);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [AWIDTH-1:0] cnt;
  logic [DWIDTH-1:0] mem [DEPTH];

  logic              mem_we;
  logic [AWIDTH-1:0] mem_wa;
  logic [DWIDTH-1:0] mem_wd;
  logic              rd_fire;
  logic [DWIDTH-1:0] rd_dat;

  always_ff @(posedge RWCLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= DO_CLEAR ? CLEAR : RUN;
      cnt       <= '0;
      INIT_BUSY <= DO_CLEAR;
    end else if (state == CLEAR) begin
      cnt <= cnt + AWIDTH'(1);
      if (cnt == '1) begin
        state     <= RUN;
        INIT_BUSY <= 1'b0;
      end
    end
  end

  // The clear sequencer takes the write port; user writes are dropped until RUN.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = WADDR;
    mem_wd = WD;
    if (RESETN) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = cnt;
        mem_wd = '0;
      end else begin
        mem_we = WEN;
      end
    end
  end

  always_ff @(posedge RWCLK) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Old-data collisions fall out of the array update landing after the read sample.
  assign rd_fire = (state == RUN) && REN;
  assign rd_dat  = (WR_THROUGH && WEN && (WADDR == RADDR)) ? WD : mem[RADDR];

  if (RDLAT == 1) begin : g_lat1
    always_ff @(posedge RWCLK or negedge RESETN) begin
      if (!RESETN) begin
        RD     <= '0;
        RVALID <= 1'b0;
      end else begin
        RVALID <= rd_fire;
        if (rd_fire) begin
          RD <= rd_dat;
        end
      end
    end
  end else if (RDLAT == 2) begin : g_lat2
    logic [DWIDTH-1:0] stage_dat;
    logic              stage_vld;

    always_ff @(posedge RWCLK or negedge RESETN) begin
      if (!RESETN) begin
        stage_dat <= '0;
        stage_vld <= 1'b0;
        RD        <= '0;
        RVALID    <= 1'b0;
      end else begin
        stage_vld <= rd_fire;
        if (rd_fire) begin
          stage_dat <= rd_dat;
        end
        RVALID <= stage_vld;
        if (stage_vld) begin
          RD <= stage_dat;
        end
      end
    end
  end else begin : g_bad_rdlat
    $error("abc_ram_dp_param: RDLAT must be 1 or 2");
  end

endmodule

// File: tb/tb_abc_ram_dp_param.sv
// Bench for two configurations: the defaults (A) and a 16x16, 2-cycle, write-through, no-clear build (B).
// Stimulus pushes expected reads into queues; a negedge monitor pops on RVALID and checks both data and arrival cycle.
module tb_abc_ram_dp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn = 1'b0;
  logic        a_wen = 0, a_ren = 0;
  logic [7:0]  a_waddr = 0, a_raddr = 0, a_wd = 0;
  logic [7:0]  a_rd;
  logic        a_rvalid, a_busy;
  logic        b_wen = 0, b_ren = 0;
  logic [3:0]  b_waddr = 0, b_raddr = 0;
  logic [15:0] b_wd = 0;
  logic [15:0] b_rd;
  logic        b_rvalid, b_busy;

  abc_ram_dp_param u_a (
    .RWCLK(clk), .RESETN(resetn), .WEN(a_wen), .REN(a_ren),
    .WADDR(a_waddr), .RADDR(a_raddr), .WD(a_wd),
    .RD(a_rd), .RVALID(a_rvalid), .INIT_BUSY(a_busy)
  );

  abc_ram_dp_param #(
    .DWIDTH(16), .AWIDTH(4), .RDLAT(2), .COLLISION_MODE(1), .CLEAR_ON_RESET(0)
  ) u_b (
    .RWCLK(clk), .RESETN(resetn), .WEN(b_wen), .REN(b_ren),
    .WADDR(b_waddr), .RADDR(b_raddr), .WD(b_wd),
    .RD(b_rd), .RVALID(b_rvalid), .INIT_BUSY(b_busy)
  );

  typedef struct {
    logic [15:0] dat;
    int          due;
    bit          chk;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  exp_t        a_q[$];
  exp_t        b_q[$];
  exp_t        ea, eb;
  logic [7:0]  ma[256];
  logic [15:0] mb[16];
  bit          mb_known[16];
  int          a_clear_left = 0;
  int          a_vld_cnt = 0;
  logic [7:0]  a_last = 0;
  logic [15:0] b_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a read result is presented.
  always @(negedge clk) begin
    if (!resetn) begin
      a_last = '0;
      b_last = '0;
    end else begin
      if (a_rvalid) begin
        a_vld_cnt++;
        if (a_q.size() == 0) begin
          check("a_spurious_rvalid", 32'(a_q.size()), 1);
        end else begin
          ea = a_q.pop_front();
          check("a_rd", 32'(a_rd), 32'(ea.dat));
          check("a_latency", 32'(cyc), 32'(ea.due));
        end
        a_last = a_rd;
      end else begin
        check("a_rd_hold", 32'(a_rd), 32'(a_last));
      end
      if (b_rvalid) begin
        if (b_q.size() == 0) begin
          check("b_spurious_rvalid", 32'(b_q.size()), 1);
        end else begin
          eb = b_q.pop_front();
          if (eb.chk) check("b_rd", 32'(b_rd), 32'(eb.dat));
          check("b_latency", 32'(cyc), 32'(eb.due));
        end
        b_last = b_rd;
      end else begin
        check("b_rd_hold", 32'(b_rd), 32'(b_last));
      end
    end
  end

  // One clock of stimulus for both instances; model updates reflect the edge about to happen.
  task automatic step(input logic wa, input logic ra, input logic [7:0] wad_a,
                      input logic [7:0] rad_a, input logic [7:0] wd_a,
                      input logic wb, input logic rb, input logic [3:0] wad_b,
                      input logic [3:0] rad_b, input logic [15:0] wd_b);
    exp_t e;
    a_wen = wa; a_ren = ra; a_waddr = wad_a; a_raddr = rad_a; a_wd = wd_a;
    b_wen = wb; b_ren = rb; b_waddr = wad_b; b_raddr = rad_b; b_wd = wd_b;
    if (a_clear_left > 0) begin
      a_clear_left--;
    end else begin
      if (ra) begin
        e.dat = {8'h00, ma[rad_a]};
        e.due = cyc + 1;
        e.chk = 1'b1;
        a_q.push_back(e);
      end
      if (wa) ma[wad_a] = wd_a;
    end
    if (rb) begin
      if (wb && wad_b == rad_b) begin
        e.dat = wd_b;
        e.chk = 1'b1;
      end else begin
        e.dat = mb[rad_b];
        e.chk = mb_known[rad_b];
      end
      e.due = cyc + 2;
      b_q.push_back(e);
    end
    if (wb) begin
      mb[wad_b] = wd_b;
      mb_known[wad_b] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("a_init_busy", 32'(a_busy), 32'(a_clear_left > 0));
    check("b_init_busy", 32'(b_busy), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h0, 8'h0, 8'h0, 0, 0, 4'h0, 4'h0, 16'h0);
  endtask

  task automatic do_reset(input int hold);
    a_wen = 0; a_ren = 0; b_wen = 0; b_ren = 0;
    resetn = 1'b0;
    #1;
    check("rst_a_rd", 32'(a_rd), 0);
    check("rst_a_rvalid", 32'(a_rvalid), 0);
    check("rst_a_busy", 32'(a_busy), 1);
    check("rst_b_rd", 32'(b_rd), 0);
    check("rst_b_rvalid", 32'(b_rvalid), 0);
    check("rst_b_busy", 32'(b_busy), 0);
    repeat (hold) @(posedge clk);
    #1;
    resetn = 1'b1;
    a_clear_left = 256;
    a_q.delete();
    b_q.delete();
    for (int i = 0; i < 256; i++) ma[i] = 8'h00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mb[i] = 16'h0;
      mb_known[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    do_reset(3);

    // Abort a clear part-way through, then let a full clear run with traffic on the ports.
    repeat (100) step($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), 8'($urandom),
                      8'($urandom), 0, 0, 4'h0, 4'h0, 16'h0);
    do_reset(2);
    a_vld_cnt = 0;
    for (int i = 0; i < 256; i++)
      step(1, 1, 8'h05, 8'($urandom), 8'hFF, 0, 0, 4'h0, 4'h0, 16'h0);
    check("a_rvalid_during_clear", 32'(a_vld_cnt), 0);

    // Full readback of the cleared array, back to back.
    for (int i = 0; i < 256; i++) step(0, 1, 8'h0, 8'(i), 8'h0, 0, 0, 4'h0, 4'h0, 16'h0);
    idle(3);
    check("a_readback_count", 32'(a_vld_cnt), 256);

    // Write then read on the next edge.
    step(1, 0, 8'h10, 8'h00, 8'hA5, 1, 0, 4'h3, 4'h0, 16'hA5A5);
    step(0, 1, 8'h00, 8'h10, 8'h00, 0, 1, 4'h0, 4'h3, 16'h0);
    idle(3);

    // Same-address collision: A returns old data, B writes through.
    step(1, 0, 8'h20, 8'h00, 8'h33, 1, 0, 4'h2, 4'h0, 16'h0033);
    step(1, 1, 8'h20, 8'h20, 8'hCC, 1, 1, 4'h2, 4'h2, 16'hCCCC);
    step(0, 1, 8'h00, 8'h20, 8'h00, 0, 1, 4'h0, 4'h2, 16'h0);
    idle(3);

    // Address extremes on B, streamed reads.
    step(0, 0, 8'h0, 8'h0, 8'h0, 1, 0, 4'hF, 4'h0, 16'hBEEF);
    step(0, 0, 8'h0, 8'h0, 8'h0, 1, 0, 4'h0, 4'h0, 16'h1234);
    step(0, 0, 8'h0, 8'h0, 8'h0, 0, 1, 4'h0, 4'hF, 16'h0);
    step(0, 0, 8'h0, 8'h0, 8'h0, 0, 1, 4'h0, 4'h0, 16'h0);
    step(0, 0, 8'h0, 8'h0, 8'h0, 0, 1, 4'h0, 4'hF, 16'h0);
    idle(3);

    // Random traffic; A addresses are often squeezed into a small window to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] wa8, ra8;
      wa8 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      ra8 = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      step($urandom_range(0, 1), $urandom_range(0, 1), wa8, ra8, 8'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), 4'($urandom),
           16'($urandom));
    end
    idle(4);
    check("a_queue_drained", 32'(a_q.size()), 0);
    check("b_queue_drained", 32'(b_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
